// File: rtl/xentry_pkg.sv
// Shared types for the L1/L2 interconnect: grant owner encoding and line geometry helpers.
package xentry_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE   = 2'd0,
        OWNER_ICACHE = 2'd1,
        OWNER_DCACHE = 2'd2
    } l2_owner_e;

    localparam int unsigned XLEN_DEFAULT      = 32;
    localparam int unsigned LINE_SIZE_DEFAULT = 16;

    function automatic int unsigned words_per_line(input int unsigned line_size,
                                                   input int unsigned xlen);
        return line_size / (xlen / 8);
    endfunction

endpackage

// File: rtl/l1_l2_arbiter.sv
// Round-robin owner of the single L2 read port, shared by the icache and dcache miss paths.
// A grant lasts one line fill (or until the owner drops access); returns are steered to the owner.
module l1_l2_arbiter
    import xentry_pkg::*;
#(
    parameter int unsigned LINE_SIZE = LINE_SIZE_DEFAULT,
    parameter int unsigned XLEN      = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ic_l2_address,
    input  logic            ic_l2_access,
    output logic [XLEN-1:0] ic_l2_word,
    output logic            ic_l2_word_valid,
    input  logic [XLEN-1:0] dc_l2_address,
    input  logic            dc_l2_access,
    output logic [XLEN-1:0] dc_l2_word,
    output logic            dc_l2_word_valid,
    output logic [XLEN-1:0] l2_address,
    output logic            l2_access,
    input  logic [XLEN-1:0] l2_word,
    input  logic            l2_word_valid,
    output l2_owner_e       grant_owner
);

    localparam int unsigned WORDS_PER_LINE = words_per_line(LINE_SIZE, XLEN);
    localparam int unsigned BEAT_W         = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    // OWNER_NONE doubles as the IDLE state; the state value is the grant owner.
    l2_owner_e         state_reg, state_next;
    l2_owner_e         last_grant_reg, last_grant_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic owner_access;
    logic last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= OWNER_NONE;
            last_grant_reg <= OWNER_DCACHE;
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    assign owner_access = (state_reg == OWNER_ICACHE) ? ic_l2_access :
                          (state_reg == OWNER_DCACHE) ? dc_l2_access : 1'b0;
    assign last_beat    = l2_word_valid && (beat_cnt_reg == LAST_BEAT);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        unique case (state_reg)
            OWNER_NONE: begin
                beat_cnt_next = '0;
                if (ic_l2_access && dc_l2_access) begin
                    // Tie: the requester that did not win last time goes first.
                    state_next = (last_grant_reg == OWNER_ICACHE) ? OWNER_DCACHE : OWNER_ICACHE;
                end else if (ic_l2_access) begin
                    state_next = OWNER_ICACHE;
                end else if (dc_l2_access) begin
                    state_next = OWNER_DCACHE;
                end
                last_grant_next = (state_next == OWNER_NONE) ? last_grant_reg : state_next;
            end
            OWNER_ICACHE, OWNER_DCACHE: begin
                if (!owner_access || last_beat) begin
                    state_next    = OWNER_NONE;
                    beat_cnt_next = '0;
                end else if (l2_word_valid) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = OWNER_NONE;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        l2_address       = '0;
        l2_access        = 1'b0;
        ic_l2_word       = '0;
        ic_l2_word_valid = 1'b0;
        dc_l2_word       = '0;
        dc_l2_word_valid = 1'b0;
        unique case (state_reg)
            OWNER_ICACHE: begin
                l2_address       = ic_l2_address;
                l2_access        = ic_l2_access;
                ic_l2_word       = l2_word;
                ic_l2_word_valid = l2_word_valid;
            end
            OWNER_DCACHE: begin
                l2_address       = dc_l2_address;
                l2_access        = dc_l2_access;
                dc_l2_word       = l2_word;
                dc_l2_word_valid = l2_word_valid;
            end
            default: ;
        endcase
    end

    assign grant_owner = state_reg;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: stimulus pushes expected beats, a negedge monitor pops and checks.
module tb_l1_l2_arbiter;
    import xentry_pkg::*;

    localparam int unsigned XLEN = 32;

    typedef struct {
        l2_owner_e   tgt;
        logic [31:0] word;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] ic_l2_address = '0;
    logic            ic_l2_access = 1'b0;
    logic [XLEN-1:0] ic_l2_word;
    logic            ic_l2_word_valid;
    logic [XLEN-1:0] dc_l2_address = '0;
    logic            dc_l2_access = 1'b0;
    logic [XLEN-1:0] dc_l2_word;
    logic            dc_l2_word_valid;
    logic [XLEN-1:0] l2_address;
    logic            l2_access;
    logic [XLEN-1:0] l2_word = '0;
    logic            l2_word_valid = 1'b0;
    l2_owner_e       grant_owner;

    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];

    l1_l2_arbiter #(.LINE_SIZE(16), .XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .ic_l2_address    (ic_l2_address),
        .ic_l2_access     (ic_l2_access),
        .ic_l2_word       (ic_l2_word),
        .ic_l2_word_valid (ic_l2_word_valid),
        .dc_l2_address    (dc_l2_address),
        .dc_l2_access     (dc_l2_access),
        .dc_l2_word       (dc_l2_word),
        .dc_l2_word_valid (dc_l2_word_valid),
        .l2_address       (l2_address),
        .l2_access        (l2_access),
        .l2_word          (l2_word),
        .l2_word_valid    (l2_word_valid),
        .grant_owner      (grant_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_beat(input l2_owner_e tgt, input logic [31:0] w);
        beat_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL stray_beat: owner %0d got word %h, expected no beat", tgt, w);
        end else begin
            e = exp_q.pop_front();
            if (e.tgt != tgt || e.word !== w) begin
                failures++;
                $display("FAIL beat: got owner %0d word %h, expected owner %0d word %h",
                         tgt, w, e.tgt, e.word);
            end else begin
                $display("beat owner=%0d word=%h ok", tgt, w);
            end
        end
    endtask

    // Monitor: any word_valid on a requester port must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (ic_l2_word_valid) check_beat(OWNER_ICACHE, ic_l2_word);
            if (dc_l2_word_valid) check_beat(OWNER_DCACHE, dc_l2_word);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ic_l2_access = 1'b0;
        dc_l2_access = 1'b0;
        l2_word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Ends on the negedge where a grant is first visible.
    task automatic wait_grant(input string nm, input l2_owner_e exp);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_owner != OWNER_NONE) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: grant timeout, got %0d expected %0d", nm, grant_owner, exp);
        end else begin
            chk(nm, 32'(grant_owner), 32'(exp));
        end
    endtask

    // Drives n L2 beats starting at the next posedge; returns at posedge+1 after the last beat.
    task automatic send_beats(input l2_owner_e tgt, input int n, input logic [31:0] base);
        beat_t e;
        step();
        for (int i = 0; i < n; i++) begin
            l2_word = base + 32'(i);
            l2_word_valid = 1'b1;
            if (tgt != OWNER_NONE) begin
                e.tgt = tgt;
                e.word = l2_word;
                exp_q.push_back(e);
            end
            step();
        end
        l2_word_valid = 1'b0;
    endtask

    task automatic check_drained(input string nm);
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    l2_owner_e order[3];

    initial begin
        order[0] = OWNER_ICACHE;
        order[1] = OWNER_DCACHE;
        order[2] = OWNER_ICACHE;

        // Reset state
        #2;
        chk("reset_owner", 32'(grant_owner), 32'(OWNER_NONE));
        chk("reset_l2_access", 32'(l2_access), 32'd0);
        chk("reset_l2_address", l2_address, 32'd0);

        // 1: dcache alone
        apply_reset();
        dc_l2_address = 32'hBEEF67BA;
        dc_l2_access = 1'b1;
        @(negedge clk);
        chk("t1_idle_no_access", 32'(l2_access), 32'd0);
        wait_grant("t1_grant_dc", OWNER_DCACHE);
        chk("t1_l2_address", l2_address, 32'hBEEF67BA);
        chk("t1_l2_access", 32'(l2_access), 32'd1);
        send_beats(OWNER_DCACHE, 4, 32'hD0000010);
        dc_l2_access = 1'b0;
        @(negedge clk);
        chk("t1_release", 32'(grant_owner), 32'(OWNER_NONE));
        check_drained("t1_drained");

        // 2+3: both requesting continuously, three fills in round-robin order
        apply_reset();
        ic_l2_address = 32'h00001000;
        dc_l2_address = 32'h00002000;
        ic_l2_access = 1'b1;
        dc_l2_access = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_grant($sformatf("t3_grant%0d", f), order[f]);
            chk($sformatf("t3_addr%0d", f), l2_address,
                (order[f] == OWNER_ICACHE) ? 32'h00001000 : 32'h00002000);
            send_beats(order[f], 4, 32'hA0000000 + 32'(f * 16));
            @(negedge clk);
            chk($sformatf("t3_idle_gap%0d", f), 32'(grant_owner), 32'(OWNER_NONE));
            check_drained($sformatf("t3_drained%0d", f));
        end
        ic_l2_access = 1'b0;
        dc_l2_access = 1'b0;

        // 4: abort after two beats, stray beat in IDLE
        apply_reset();
        ic_l2_address = 32'h00003000;
        ic_l2_access = 1'b1;
        wait_grant("t4_grant_ic", OWNER_ICACHE);
        send_beats(OWNER_ICACHE, 2, 32'h11110000);
        ic_l2_access = 1'b0;
        @(negedge clk);
        chk("t4_access_drop", 32'(l2_access), 32'd0);
        step();
        l2_word = 32'hDEADDEAD;
        l2_word_valid = 1'b1;
        @(negedge clk);
        chk("t4_idle", 32'(grant_owner), 32'(OWNER_NONE));
        chk("t4_stray_ic", {31'd0, ic_l2_word_valid}, 32'd0);
        chk("t4_stray_dc", {31'd0, dc_l2_word_valid}, 32'd0);
        chk("t4_stray_ic_word", ic_l2_word, 32'd0);
        step();
        l2_word_valid = 1'b0;
        check_drained("t4_drained");

        // 5: reset mid-fill, then a clean fill
        apply_reset();
        ic_l2_address = 32'h00004000;
        ic_l2_access = 1'b1;
        wait_grant("t5_grant_ic", OWNER_ICACHE);
        send_beats(OWNER_ICACHE, 1, 32'h55550000);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_owner", 32'(grant_owner), 32'(OWNER_NONE));
        chk("t5_async_access", 32'(l2_access), 32'd0);
        #2;
        reset = 1'b0;
        wait_grant("t5_regrant", OWNER_ICACHE);
        send_beats(OWNER_ICACHE, 4, 32'h66660000);
        @(negedge clk);
        chk("t5_full_line", 32'(grant_owner), 32'(OWNER_NONE));
        ic_l2_access = 1'b0;
        check_drained("t5_drained");

        // 6: dcache toggles while icache owns the port
        apply_reset();
        ic_l2_address = 32'h00005000;
        ic_l2_access = 1'b1;
        wait_grant("t6_grant_ic", OWNER_ICACHE);
        step();
        for (int i = 0; i < 3; i++) begin
            beat_t e;
            dc_l2_access = (i % 2 == 0);
            dc_l2_address = 32'h0000F000 + 32'(i);
            ic_l2_address = 32'h00005000 + 32'(i * 4);
            l2_word = 32'h77770000 + 32'(i);
            l2_word_valid = 1'b1;
            e.tgt = OWNER_ICACHE;
            e.word = l2_word;
            exp_q.push_back(e);
            @(negedge clk);
            chk($sformatf("t6_addr%0d", i), l2_address, 32'h00005000 + 32'(i * 4));
            chk($sformatf("t6_access%0d", i), 32'(l2_access), 32'd1);
            chk($sformatf("t6_dc_valid%0d", i), {31'd0, dc_l2_word_valid}, 32'd0);
            chk($sformatf("t6_dc_word%0d", i), dc_l2_word, 32'd0);
            step();
        end
        dc_l2_access = 1'b0;
        l2_word_valid = 1'b0;
        send_beats(OWNER_ICACHE, 1, 32'h77770003);
        @(negedge clk);
        chk("t6_release", 32'(grant_owner), 32'(OWNER_NONE));
        ic_l2_access = 1'b0;
        check_drained("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
